// File: rtl/aud_pkg.sv
// Shared audio definitions for the codec record and playback paths.
//   AUD_DATA_W  : default sample width per channel.
//   rx_state_t  : capture FSM states of the I2S ADC receiver.
package aud_pkg;

    localparam int AUD_DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_LEFT   = 3'd2,
        S_WAIT_R = 3'd3,
        S_RIGHT  = 3'd4,
        S_WAIT_L = 3'd5
    } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous line, with a registered copy of
// the synchronized level used for single-cycle edge strobes.
//   i_clk    : system clock
//   i_rst    : synchronous active-high reset (clears every flop)
//   i_async  : asynchronous input line
//   o_level  : synchronized level (STAGES flops deep)
//   o_rise   : one-cycle strobe, synchronized level went 0 -> 1
//   o_fall   : one-cycle strobe, synchronized level went 1 -> 0
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // Fewer than two flops is not a safe synchronizer; clamp to two.
    localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;
    logic             prev_q;
    logic             prev_d;

    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], i_async};
        prev_d = sync_q[DEPTH-1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_level = sync_q[DEPTH-1];
    assign o_rise  = sync_q[DEPTH-1] & ~prev_q;
    assign o_fall  = ~sync_q[DEPTH-1] & prev_q;

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S ADC receiver for the WM8731 record path (codec is clock master).
// BCLK, ADCLRCK and ADCDAT are oversampled in the i_clk domain; BCLK is only
// ever treated as data. Each completed left/right pair is offered as one
// parallel frame on a valid/ready handshake.
//   i_clk, i_rst           : system clock, synchronous active-high reset
//   i_en                   : capture enable (level)
//   i_bclk/i_lrck/i_adcdat : asynchronous codec serial port (lrck low = left)
//   o_data_l/o_data_r      : captured two's-complement samples
//   o_valid/i_ready        : frame handshake
//   o_overrun/i_clr_ovr    : sticky dropped-frame flag and its clear
//   o_busy                 : capture FSM is not idle
module i2s_adc_receiver
    import aud_pkg::*;
#(
    parameter int DATA_W      = AUD_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_bclk,
    input  logic              i_lrck,
    input  logic              i_adcdat,
    output logic [DATA_W-1:0] o_data_l,
    output logic [DATA_W-1:0] o_data_r,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_overrun,
    input  logic              i_clr_ovr,
    output logic              o_busy
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // ------------------------------------------------------------------
    // Input synchronization: all three lines use identical depth so the
    // relative order of BCLK, LRCK and data transitions is preserved.
    // ------------------------------------------------------------------
    logic bclk_rise;
    logic bclk_level_unused;
    logic bclk_fall_unused;
    logic lrck_rise;
    logic lrck_fall;
    logic lrck_level_unused;
    logic adcdat_bit;
    logic adcdat_rise_unused;
    logic adcdat_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_bclk),
        .o_level (bclk_level_unused),
        .o_rise  (bclk_rise),
        .o_fall  (bclk_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrck (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_lrck),
        .o_level (lrck_level_unused),
        .o_rise  (lrck_rise),
        .o_fall  (lrck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_adcdat (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_adcdat),
        .o_level (adcdat_bit),
        .o_rise  (adcdat_rise_unused),
        .o_fall  (adcdat_fall_unused)
    );

    // ------------------------------------------------------------------
    // Capture FSM state
    // ------------------------------------------------------------------
    rx_state_t          state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               skip_q,    skip_d;     // next BCLK rise is the I2S delay slot
    logic [DATA_W-1:0]  shl_q,     shl_d;
    logic [DATA_W-1:0]  shr_q,     shr_d;
    logic               busy_q,    busy_d;
    logic               frame_done;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        skip_d     = skip_q;
        shl_d      = shl_q;
        shr_d      = shr_q;
        frame_done = 1'b0;

        if (!i_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SYNC;
                end
                S_SYNC: begin
                    // Only a left-channel start is a safe frame boundary.
                    if (lrck_fall) begin
                        state_d = S_LEFT;
                        cnt_d   = '0;
                        skip_d  = 1'b1;
                    end
                end
                S_LEFT: begin
                    // Any LRCK edge here means the channel was short.
                    if (lrck_rise || lrck_fall) begin
                        state_d = S_SYNC;
                    end else if (bclk_rise) begin
                        if (skip_q) begin
                            skip_d = 1'b0;
                        end else begin
                            shl_d = {shl_q[DATA_W-2:0], adcdat_bit};
                            cnt_d = cnt_q + CNT_W'(1);
                            if (cnt_q == LAST_BIT) begin
                                state_d = S_WAIT_R;
                            end
                        end
                    end
                end
                S_WAIT_R: begin
                    // Surplus slot bits are ignored until the channel flips.
                    if (lrck_rise) begin
                        state_d = S_RIGHT;
                        cnt_d   = '0;
                        skip_d  = 1'b1;
                    end
                end
                S_RIGHT: begin
                    if (lrck_rise || lrck_fall) begin
                        state_d = S_SYNC;
                    end else if (bclk_rise) begin
                        if (skip_q) begin
                            skip_d = 1'b0;
                        end else begin
                            shr_d = {shr_q[DATA_W-2:0], adcdat_bit};
                            cnt_d = cnt_q + CNT_W'(1);
                            if (cnt_q == LAST_BIT) begin
                                state_d    = S_WAIT_L;
                                frame_done = 1'b1;
                            end
                        end
                    end
                end
                S_WAIT_L: begin
                    if (lrck_fall) begin
                        state_d = S_LEFT;
                        cnt_d   = '0;
                        skip_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Output frame register and handshake
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] data_l_q, data_l_d;
    logic [DATA_W-1:0] data_r_q, data_r_d;
    logic              valid_q,  valid_d;
    logic              ovr_q,    ovr_d;

    always_comb begin
        data_l_d = data_l_q;
        data_r_d = data_r_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        if (i_clr_ovr) begin
            ovr_d = 1'b0;
        end

        // A completing frame loads if the slot is empty or being emptied this
        // cycle; otherwise it is dropped and the held frame stays stable.
        // Placed after the clear so a simultaneous set wins.
        if (frame_done) begin
            if (!valid_q || i_ready) begin
                data_l_d = shl_d;
                data_r_d = shr_d;
                valid_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            skip_q   <= 1'b0;
            shl_q    <= '0;
            shr_q    <= '0;
            busy_q   <= 1'b0;
            data_l_q <= '0;
            data_r_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            skip_q   <= skip_d;
            shl_q    <= shl_d;
            shr_q    <= shr_d;
            busy_q   <= busy_d;
            data_l_q <= data_l_d;
            data_r_q <= data_r_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign o_data_l  = data_l_q;
    assign o_data_r  = data_r_q;
    assign o_valid   = valid_q;
    assign o_overrun = ovr_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: BCLK = i_clk/8, codec lines change while
// BCLK is low. Expected frames go into a scoreboard queue; a monitor pops and
// compares on every accepted frame.
module tb_i2s_adc_receiver;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          bclk;
    logic          lrck;
    logic          adcdat;
    logic [DW-1:0] data_l;
    logic [DW-1:0] data_r;
    logic          valid;
    logic          ready;
    logic          overrun;
    logic          clr_ovr;
    logic          busy;

    always #5 clk = ~clk;

    i2s_adc_receiver #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_bclk    (bclk),
        .i_lrck    (lrck),
        .i_adcdat  (adcdat),
        .o_data_l  (data_l),
        .o_data_r  (data_r),
        .o_valid   (valid),
        .i_ready   (ready),
        .o_overrun (overrun),
        .i_clr_ovr (clr_ovr),
        .o_busy    (busy)
    );

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } frame_t;

    frame_t sb_q[$];
    frame_t mon_exp;
    int     n_vec  = 0;
    int     n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // One BCLK period: data set while low, 4 clocks low, 4 clocks high.
    task automatic send_bit(input logic b);
        adcdat = b;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        repeat (4) @(negedge clk);
        bclk = 1'b0;
    endtask

    // Sends the top n bits of w, MSB first.
    task automatic send_raw(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(w[31-i]);
        end
    endtask

    // LRCK edge, delay slot, then n bits.
    task automatic send_chan(input logic lr, input logic [31:0] w, input int n);
        lrck = lr;
        send_bit(1'b1);
        send_raw(w, n);
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        send_chan(1'b0, {l, 16'h0000}, DW);
        send_chan(1'b1, {r, 16'h0000}, DW);
    endtask

    task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
        frame_t f;
        f.l = l;
        f.r = r;
        sb_q.push_back(f);
    endtask

    // Monitor: just after the falling edge the handshake inputs are settled,
    // so valid & ready here means the next rising edge transfers the frame.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (valid === 1'b1 && ready === 1'b1) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame: got L=%h R=%h, expected no frame", data_l, data_r);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if (data_l !== mon_exp.l || data_r !== mon_exp.r) begin
                        n_fail++;
                        $display("FAIL frame: got L=%h R=%h, expected L=%h R=%h",
                                 data_l, data_r, mon_exp.l, mon_exp.r);
                    end else begin
                        $display("ok   frame: L=%h R=%h", data_l, data_r);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        rst     = 1'b1;
        en      = 1'b0;
        bclk    = 1'b0;
        lrck    = 1'b1;
        adcdat  = 1'b0;
        ready   = 1'b0;
        clr_ovr = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_valid",   32'(valid),   32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_data",    {data_l, data_r}, 32'h0);

        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        chk("busy_after_en", 32'(busy), 32'h1);
        repeat (4) @(negedge clk);

        // Basic frame with exact output latency and one-cycle handshake.
        push(16'hA5C3, 16'h5A3C);
        send_chan(1'b0, {16'hA5C3, 16'h0000}, DW);
        send_chan(1'b1, {16'h5A3C, 16'h0000}, DW - 1);
        adcdat = 1'b0;                      // LSB of 5A3C
        repeat (4) @(negedge clk);
        bclk = 1'b1;                        // edge k is the next rising edge
        repeat (2) @(negedge clk);
        chk("valid_not_before_k2", 32'(valid), 32'h0);
        @(negedge clk);
        chk("valid_at_k2", 32'(valid), 32'h1);
        ready = 1'b1;
        @(negedge clk);
        chk("valid_falls_after_accept", 32'(valid), 32'h0);
        @(negedge clk);
        bclk = 1'b0;

        // Enable raised mid-left-channel: that frame must not appear.
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_when_disabled", 32'(busy), 32'h0);
        w    = {16'h1234, 16'h0000};
        lrck = 1'b0;
        send_bit(1'b1);
        send_raw(w, 6);
        en = 1'b1;
        send_raw(w << 6, 10);
        send_chan(1'b1, {16'h4321, 16'h0000}, DW);
        push(16'h0F1E, 16'h2D3C);
        send_frame(16'h0F1E, 16'h2D3C);
        chk("en_mid_frame_drained", 32'(sb_q.size()), 32'h0);

        // 32-bit slots: trailing bits ignored.
        push(16'h8001, 16'h7FFE);
        send_chan(1'b0, 32'h8001_ABCD, 32);
        send_chan(1'b1, 32'h7FFE_1357, 32);
        chk("slot32_drained", 32'(sb_q.size()), 32'h0);

        // Overrun: consumer stalls across two frames.
        ready = 1'b0;
        push(16'h1111, 16'h2222);
        send_frame(16'h1111, 16'h2222);
        chk("held_valid",      32'(valid),   32'h1);
        chk("no_overrun_yet",  32'(overrun), 32'h0);
        send_frame(16'h3333, 16'h4444);
        chk("overrun_set",     32'(overrun), 32'h1);
        chk("held_data",       {data_l, data_r}, 32'h1111_2222);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("overrun_cleared", 32'(overrun), 32'h0);
        ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("overrun_drained", 32'(sb_q.size()), 32'h0);

        // Short left channel (10 bits): frame discarded.
        send_chan(1'b0, {16'hDEAD, 16'h0000}, 10);
        send_chan(1'b1, {16'hBEEF, 16'h0000}, DW);
        chk("short_no_valid", 32'(valid), 32'h0);
        push(16'hCAFE, 16'h0F0F);
        send_frame(16'hCAFE, 16'h0F0F);
        chk("short_drained", 32'(sb_q.size()), 32'h0);

        // Reset in the middle of a right channel.
        ready = 1'b0;
        send_frame(16'h1357, 16'h2468);
        chk("pre_reset_valid", 32'(valid), 32'h1);
        send_chan(1'b0, {16'h9999, 16'h0000}, DW);
        w    = {16'h7777, 16'h0000};
        lrck = 1'b1;
        send_bit(1'b1);
        send_raw(w, 8);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_valid",   32'(valid),   32'h0);
        chk("reset_data",    {data_l, data_r}, 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        chk("reset_busy",    32'(busy),    32'h0);
        rst   = 1'b0;
        ready = 1'b1;
        send_raw(w << 8, 8);
        chk("post_reset_no_valid", 32'(valid), 32'h0);
        push(16'h0BAD, 16'hF00D);
        send_frame(16'h0BAD, 16'hF00D);

        // Bounded drain of anything still expected.
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
            @(negedge clk);
        end
        chk("final_drained", 32'(sb_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_adc_receiver.md
# i2s_adc_receiver

Captures stereo PCM samples from the WM8731 codec ADC serial port (ADCDAT/ADCLRCK/BCLK, I2S format, codec as clock master) and presents each left/right pair as one parallel frame on a valid/ready handshake. It is the record-direction counterpart of the DAC playback path. Its frames feed the loop-record path in S_RECD_LOOP and the live effect chain in S_PLAY/S_SET. All codec lines are oversampled in the system clock domain; BCLK is never used as a clock.

## Interface
Parameters:
- DATA_W, 16: bits per channel captured, MSB first.
- SYNC_STAGES, 2: synchronizer flops per codec input, minimum 2.

Ports:
- i_clk  in  1  system clock; must be ≥ 8× BCLK frequency.
- i_rst  in  1  reset; one clock; reset is synchronous and active-high.
- i_en  in  1  capture enable (level).
- i_bclk  in  1  codec bit clock, asynchronous.
- i_lrck  in  1  codec ADCLRCK, asynchronous; low = left, high = right.
- i_adcdat  in  1  codec ADC serial data, asynchronous.
- o_data_l  out  DATA_W  left sample, two's complement.
- o_data_r  out  DATA_W  right sample, two's complement.
- o_valid  out  1  frame available.
- i_ready  in  1  consumer accepts frame.
- o_overrun  out  1  sticky: a completed frame was dropped.
- i_clr_ovr  in  1  clears o_overrun.
- o_busy  out  1  FSM not in S_IDLE.

## Operation
- Inputs pass through SYNC_STAGES flops, all with equal depth, so relative ordering is preserved.
- bclk_rise = sync_bclk & ~prev_bclk.
- lrck_fall and lrck_rise are derived the same way.
- The data bit is the synchronized i_adcdat, sampled in the cycle in which bclk_rise is high.
- I2S framing: the first bclk_rise after an LRCK edge is the delay slot and is skipped. The next DATA_W rises carry MSB..LSB. Further rises until the next LRCK edge are ignored, so 24/32-bit slots are tolerated.
- FSM states:
  - S_IDLE: entered from reset and whenever i_en=0; exits to S_SYNC when i_en=1.
  - S_SYNC: waits for lrck_fall, then goes to S_LEFT with the bit counter cleared and the delay-slot flag set. Capture never starts mid-frame.
  - S_LEFT: shifts DATA_W bits into the left shift register. On the last bit, goes to S_WAIT_R.
  - S_WAIT_R: waits for lrck_rise, then goes to S_RIGHT.
  - S_RIGHT: shifts DATA_W bits. On the last bit, the frame is complete; go to S_WAIT_L.
  - S_WAIT_L: on lrck_fall, goes to S_LEFT.
- Short channel: an LRCK edge in S_LEFT/S_RIGHT before DATA_W bits have been shifted discards the partial frame and returns the FSM to S_SYNC.
- i_en dropping in any state: S_IDLE on the next edge, partial frame discarded. o_valid, the data outputs and o_overrun are unaffected.
- Frame completion, by case:
  - o_valid=0: latch both shift registers into o_data_l/o_data_r and set o_valid=1.
  - o_valid=1 and i_ready=1 in the same cycle: the old frame transfers, the new frame loads, o_valid stays 1.
  - o_valid=1 and i_ready=0: the new frame is dropped, output data is held, o_overrun is set.
- Transfer occurs on any cycle with o_valid & i_ready. o_valid clears on the next edge unless a frame completes in that same cycle.
- o_data_* is stable while o_valid=1 and not accepted.
- i_clr_ovr clears o_overrun. If a set and a clear occur in the same cycle, set wins.
- Reset values:
  - o_valid=0, o_overrun=0, o_busy=0.
  - o_data_l=0, o_data_r=0.
  - FSM in S_IDLE; shift registers, counter and sync flops all 0.
- Reset mid-frame aborts all activity the same way.

## Timing
- Let edge k be the first i_clk edge that samples raw i_bclk high for the last right-channel bit. bclk_rise is visible after edge k+SYNC_STAGES−1, and o_valid=1 after edge k+SYNC_STAGES (edge k+2 for the default).
- o_busy is registered and reflects state_r.
- Handshake response is one cycle: o_valid falls the edge after acceptance.
- Throughput: one frame per LRCK period. The consumer has a full LRCK period (≥ 2·(DATA_W+1)·8 i_clk cycles) to accept before an overrun occurs.
- No combinational path from i_ready to any output.

## Structure
- Shared package aud_pkg:
  - enum type rx_state_t (the six states above);
  - DATA_W default as a localparam AUD_DATA_W = 16, shared with the DAC path.
- Sub-module sync_edge: an SYNC_STAGES-deep synchronizer with registered previous value, outputs level/rise/fall. Instantiated for bclk and lrck; its level output is used for adcdat.
- Bit counter width is $clog2(DATA_W+1).

## Test plan
- Reset, then i_en=1, BCLK = i_clk/8, stereo frames L=16'hA5C3, R=16'h5A3C → o_valid rises SYNC_STAGES cycles after the last R bit's BCLK rise, with o_data_l=A5C3 and o_data_r=5A3C; i_ready=1 → o_valid falls next cycle.
- i_en raised mid-left-channel → that frame is not reported; the first frame reported is the next full one.
- 32-bit slots with L=16'h8001 followed by 16 junk bits → o_data_l=8001, extra bits ignored.
- i_ready held 0 across two frames → first frame held, o_overrun=1 after the second completes; i_clr_ovr pulse → 0.
- LRCK rises after 10 left bits → no o_valid for that frame; the next full frame is captured correctly.
- i_rst asserted mid-right-channel → the next edge shows all outputs 0 and o_busy=0; capture resumes only from the next lrck_fall.
